hazard_spawn_scheduler: RTL and testbench
=========================================

// Module: hazard_spawn_scheduler
// PURPOSE
//  Schedules spawning of the Bullet Bill, Koopa shell and Dragon Coin objects that the game
//  datapath moves and draws. Per-object frame-based cooldowns with LFSR jitter; one spawn per
//  video frame; a cap on simultaneous hazards. Drives billSpawn/shellSpawn/dragoncoinSpawn
//  and a spawn lane into the game logic and VGA object renderers.
// PARAMETERS
//  COOL_BILL   120      frames from bill done/start to bill eligible
//  COOL_SHELL  180      frames from shell done/start to shell eligible
//  COOL_DCOIN  600      frames from dragon coin done/start to coin eligible
//  JITTER_BITS 5        LFSR bits added to each cooldown load (0 = no jitter)
//  MAX_HAZ     1        max simultaneously active hazards (bill+shell), 1..2
//  LFSR_SEED   16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous reset, active LOW
//  frame_tick      in   1   1-cycle pulse, once per video frame
//  start           in   1   1-cycle pulse: begin/restart a round
//  gameOver        in   1   level: win or lose reached
//  bill_done       in   1   1-cycle pulse: bill left screen
//  shell_done      in   1   1-cycle pulse: shell left screen
//  dcoin_done      in   1   1-cycle pulse: dragon coin collected or expired
//  billSpawn       out  1   level: bill active
//  shellSpawn      out  1   level: shell active
//  dragoncoinSpawn out  1   level: dragon coin active
//  spawn_pulse     out  1   1-cycle pulse on each spawn
//  spawn_id        out  2   object of last spawn: 0 bill, 1 shell, 2 dcoin
//  spawn_lane      out  2   lane index (LFSR[1:0]) latched at last spawn
//  state           out  2   0 IDLE, 1 RUN, 2 FROZEN
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; all spawn flags, spawn_pulse, spawn_id,
//    spawn_lane = 0; cooldown counters = 0; rr pointer = bill; lfsr = LFSR_SEED.
//  - LFSR: 16-bit Galois, mask 16'hB400, steps every clk cycle outside reset.
//  - jitter = JITTER_BITS==0 ? 0 : lfsr[JITTER_BITS-1:0]. Counters 11 bit unsigned;
//    COOL_x + 2^JITTER_BITS - 1 must be < 2048 (elaboration-time check).
//  - FSM: IDLE --start--> RUN; RUN --gameOver--> FROZEN; FROZEN --start--> RUN.
//    start has priority over gameOver in the same cycle. start in RUN = restart.
//  - On any transition into RUN: all flags cleared; each counter loaded COOL_x + jitter
//    (same lfsr value for all three); rr pointer = bill.
//  - IDLE: no counting, no spawns. FROZEN: flags, counters, spawn_id/lane hold; done
//    pulses ignored; no spawns; spawn_pulse 0.
//  - RUN, on frame_tick: each inactive object with counter>0 decrements by 1. An inactive
//    object with counter==0 is eligible. Active objects' counters hold.
//  - Arbitration (RUN, frame_tick, at most one grant): dcoin eligible wins; else among
//    eligible bill/shell, grant only if active hazard count < MAX_HAZ; if both eligible,
//    rr pointer chooses, then pointer toggles to the other. Losers stay eligible at 0.
//  - Grant: next cycle flag=1, spawn_pulse=1 (one cycle), spawn_id, spawn_lane=lfsr[1:0].
//  - x_done while flag==1 (RUN): next cycle flag=0, counter = COOL_x + jitter.
//    x_done while flag==0: ignored. done and frame_tick in the same cycle: done is applied,
//    the object is not eligible on that tick.
//  - spawn_pulse is 0 in every cycle other than the grant cycle+1.
// TESTING
//  JITTER_BITS=0, COOL_BILL=4, COOL_SHELL=4, COOL_DCOIN=20, MAX_HAZ=1 unless stated.
//  1 rst low 2 cycles -> all outputs 0, state=0; start -> state=1 next cycle.
//  2 start, 5 frame_ticks -> spawn_pulse after 5th tick, spawn_id=0, billSpawn=1.
//  3 bill active, shell reaches 0 -> no shell spawn until bill_done; bill_done then next tick
//    -> shellSpawn=1, spawn_id=1.
//  4 MAX_HAZ=2, bill and shell eligible same tick -> bill first, shell on next tick; repeat
//    after both done -> shell first (round robin).
//  5 dcoin and bill eligible same tick -> dragoncoinSpawn=1, spawn_id=2, bill one tick later.
//  6 gameOver in RUN -> state=2, flags held, done ignored, no spawns for 50 ticks; start ->
//    flags 0, bill spawns after 5 ticks; rst low mid-RUN -> full reset values next cycle.

Source files
------------

// File: rtl/hazard_spawn_scheduler.sv
// Hazard spawn scheduler: frame-based cooldowns with LFSR jitter for bill, shell and dragon coin.
// It grants at most one spawn per video frame and caps the number of simultaneously active hazards.
module hazard_spawn_scheduler #(
   parameter int          COOL_BILL   = 120,
   parameter int          COOL_SHELL  = 180,
   parameter int          COOL_DCOIN  = 600,
   parameter int          JITTER_BITS = 5,
   parameter int          MAX_HAZ     = 1,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       gameOver,
   input  logic       bill_done,
   input  logic       shell_done,
   input  logic       dcoin_done,
   output logic       billSpawn,
   output logic       shellSpawn,
   output logic       dragoncoinSpawn,
   output logic       spawn_pulse,
   output logic [1:0] spawn_id,
   output logic [1:0] spawn_lane,
   output logic [1:0] state
);

   // state  | meaning
   // IDLE   | before the first start; nothing counts, nothing spawns
   // RUN    | cooldowns count on frame_tick, spawns are granted
   // FROZEN | game over; flags, counters and last spawn info hold until start
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } stateT;

   if (JITTER_BITS < 0 || JITTER_BITS > 11) begin : gBadJitter
      $error("JITTER_BITS must be in 0..11");
   end
   if ((COOL_BILL + (1 << JITTER_BITS) - 1) >= 2048 ||
       (COOL_SHELL + (1 << JITTER_BITS) - 1) >= 2048 ||
       (COOL_DCOIN + (1 << JITTER_BITS) - 1) >= 2048) begin : gBadCool
      $error("cooldown plus maximum jitter does not fit the 11-bit counters");
   end
   if (MAX_HAZ < 1 || MAX_HAZ > 2) begin : gBadMaxHaz
      $error("MAX_HAZ must be 1 or 2");
   end
   if (LFSR_SEED == 16'h0000) begin : gBadSeed
      $error("LFSR_SEED must be nonzero");
   end

   localparam logic [10:0] JIT_MASK   = 11'((1 << JITTER_BITS) - 1);
   localparam logic [10:0] LOAD_BILL  = 11'(COOL_BILL);
   localparam logic [10:0] LOAD_SHELL = 11'(COOL_SHELL);
   localparam logic [10:0] LOAD_DCOIN = 11'(COOL_DCOIN);
   localparam logic [1:0]  MAX_HAZ_W  = 2'(MAX_HAZ);

   stateT       curState;
   stateT       nxtState;

   logic [15:0] lfsr;
   logic [15:0] lfsrNext;
   logic [10:0] jitter;
   logic [10:0] cntBill;
   logic [10:0] cntShell;
   logic [10:0] cntDcoin;
   logic        rrShell;

   logic        runActive;
   logic        billRetire;
   logic        shellRetire;
   logic        dcoinRetire;
   logic        billElig;
   logic        shellElig;
   logic        dcoinElig;
   logic [1:0]  hazCnt;
   logic        hazRoom;
   logic        grantBill;
   logic        grantShell;
   logic        grantDcoin;
   logic        grantAny;
   logic [1:0]  grantId;
   logic        rrToggle;

   always_ff @(posedge clk) begin
      if (!rst) begin
         curState <= IDLE;
      end else begin
         curState <= nxtState;
      end
   end

   always_comb begin
      nxtState = curState;
      if (start) begin
         nxtState = RUN;
      end else if (curState == RUN && gameOver) begin
         nxtState = FROZEN;
      end
   end

   assign state = curState;

   assign lfsrNext = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   assign jitter   = lfsr[10:0] & JIT_MASK;

   // A start in RUN is a restart, so normal run processing is suppressed in that cycle.
   assign runActive = (curState == RUN) && !start;

   assign billRetire  = runActive && bill_done  && billSpawn;
   assign shellRetire = runActive && shell_done && shellSpawn;
   assign dcoinRetire = runActive && dcoin_done && dragoncoinSpawn;

   assign billElig  = runActive && frame_tick && !billSpawn       && (cntBill  == 11'd0);
   assign shellElig = runActive && frame_tick && !shellSpawn      && (cntShell == 11'd0);
   assign dcoinElig = runActive && frame_tick && !dragoncoinSpawn && (cntDcoin == 11'd0);

   assign hazCnt  = {1'b0, billSpawn} + {1'b0, shellSpawn};
   assign hazRoom = hazCnt < MAX_HAZ_W;

   always_comb begin
      grantBill  = 1'b0;
      grantShell = 1'b0;
      grantDcoin = 1'b0;
      rrToggle   = 1'b0;
      if (dcoinElig) begin
         grantDcoin = 1'b1;
      end else if (hazRoom) begin
         if (billElig && shellElig) begin
            grantBill  = !rrShell;
            grantShell = rrShell;
            rrToggle   = 1'b1;
         end else begin
            grantBill  = billElig;
            grantShell = shellElig;
         end
      end
   end

   assign grantAny = grantBill || grantShell || grantDcoin;
   assign grantId  = grantDcoin ? 2'd2 : (grantShell ? 2'd1 : 2'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr            <= LFSR_SEED;
         billSpawn       <= 1'b0;
         shellSpawn      <= 1'b0;
         dragoncoinSpawn <= 1'b0;
         spawn_pulse     <= 1'b0;
         spawn_id        <= 2'd0;
         spawn_lane      <= 2'd0;
         cntBill         <= 11'd0;
         cntShell        <= 11'd0;
         cntDcoin        <= 11'd0;
         rrShell         <= 1'b0;
      end else begin
         lfsr        <= lfsrNext;
         spawn_pulse <= 1'b0;
         if (start) begin
            billSpawn       <= 1'b0;
            shellSpawn      <= 1'b0;
            dragoncoinSpawn <= 1'b0;
            cntBill         <= LOAD_BILL  + jitter;
            cntShell        <= LOAD_SHELL + jitter;
            cntDcoin        <= LOAD_DCOIN + jitter;
            rrShell         <= 1'b0;
         end else if (curState == RUN) begin
            // A retiring object reloads instead of counting, so it cannot be eligible on that tick.
            if (billRetire) begin
               billSpawn <= 1'b0;
               cntBill   <= LOAD_BILL + jitter;
            end else if (frame_tick && !billSpawn && cntBill != 11'd0) begin
               cntBill <= cntBill - 11'd1;
            end

            if (shellRetire) begin
               shellSpawn <= 1'b0;
               cntShell   <= LOAD_SHELL + jitter;
            end else if (frame_tick && !shellSpawn && cntShell != 11'd0) begin
               cntShell <= cntShell - 11'd1;
            end

            if (dcoinRetire) begin
               dragoncoinSpawn <= 1'b0;
               cntDcoin        <= LOAD_DCOIN + jitter;
            end else if (frame_tick && !dragoncoinSpawn && cntDcoin != 11'd0) begin
               cntDcoin <= cntDcoin - 11'd1;
            end

            if (grantBill) begin
               billSpawn <= 1'b1;
            end
            if (grantShell) begin
               shellSpawn <= 1'b1;
            end
            if (grantDcoin) begin
               dragoncoinSpawn <= 1'b1;
            end
            if (grantAny) begin
               spawn_pulse <= 1'b1;
               spawn_id    <= grantId;
               spawn_lane  <= lfsr[1:0];
            end
            if (rrToggle) begin
               rrShell <= ~rrShell;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_spawn_scheduler.sv
// Scoreboard bench for hazard_spawn_scheduler: two instances (MAX_HAZ 1 and 2) share stimulus,
// each held in reset while the other is exercised; a monitor per instance checks every spawn pulse.
module tb_hazard_spawn_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstA, rstB, frameTick, start, gameOver, billDone, shellDone, dcoinDone;
   logic billA, shellA, dcoinA, pulseA;
   logic [1:0] idA, laneA, stateA;
   logic billB, shellB, dcoinB, pulseB;
   logic [1:0] idB, laneB, stateB;

   int nCompared = 0;
   int nMismatched = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [1:0] lane;
      logic [2:0] flags;
   } expT;

   expT qA[$];
   expT qB[$];
   logic [15:0] lfsrA, lfsrB;
   logic [1:0] lastLaneA;
   bit selB = 1'b0;

   hazard_spawn_scheduler #(
      .COOL_BILL(4), .COOL_SHELL(4), .COOL_DCOIN(20), .JITTER_BITS(0), .MAX_HAZ(1),
      .LFSR_SEED(16'hACE1)
   ) dutA (
      .clk(clk), .rst(rstA), .frame_tick(frameTick), .start(start), .gameOver(gameOver),
      .bill_done(billDone), .shell_done(shellDone), .dcoin_done(dcoinDone),
      .billSpawn(billA), .shellSpawn(shellA), .dragoncoinSpawn(dcoinA),
      .spawn_pulse(pulseA), .spawn_id(idA), .spawn_lane(laneA), .state(stateA)
   );

   hazard_spawn_scheduler #(
      .COOL_BILL(4), .COOL_SHELL(4), .COOL_DCOIN(20), .JITTER_BITS(0), .MAX_HAZ(2),
      .LFSR_SEED(16'hACE1)
   ) dutB (
      .clk(clk), .rst(rstB), .frame_tick(frameTick), .start(start), .gameOver(gameOver),
      .bill_done(billDone), .shell_done(shellDone), .dcoin_done(dcoinDone),
      .billSpawn(billB), .shellSpawn(shellB), .dragoncoinSpawn(dcoinB),
      .spawn_pulse(pulseB), .spawn_id(idB), .spawn_lane(laneB), .state(stateB)
   );

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Reference LFSR per instance: Galois 0xB400, reloaded with the seed while in reset.
   always @(posedge clk) begin
      lfsrA <= !rstA ? 16'hACE1 : lfsrStep(lfsrA);
      lfsrB <= !rstB ? 16'hACE1 : lfsrStep(lfsrB);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      expT e;
      if (pulseA !== 1'b0) begin
         if (qA.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL A_unexpected_spawn: got id %0d flags %b expected no spawn",
                     idA, {billA, shellA, dcoinA});
         end else begin
            e = qA.pop_front();
            check("A_spawn_id", idA, e.id);
            check("A_spawn_lane", laneA, e.lane);
            check("A_spawn_flags", {billA, shellA, dcoinA}, e.flags);
         end
      end
   end

   always @(negedge clk) begin
      expT e;
      if (pulseB !== 1'b0) begin
         if (qB.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL B_unexpected_spawn: got id %0d flags %b expected no spawn",
                     idB, {billB, shellB, dcoinB});
         end else begin
            e = qB.pop_front();
            check("B_spawn_id", idB, e.id);
            check("B_spawn_lane", laneB, e.lane);
            check("B_spawn_flags", {billB, shellB, dcoinB}, e.flags);
         end
      end
   end

   // One frame tick (optionally with done pulses in the same cycle); the expected spawn is queued
   // just before the granting edge, and must have been consumed by the monitor one cycle later.
   task automatic tick(input bit expSpawn, input logic [2:0] doneBits,
                       input logic [1:0] expId, input logic [2:0] expFlags);
      expT e;
      @(negedge clk);
      if (expSpawn) begin
         e.id    = expId;
         e.flags = expFlags;
         e.lane  = selB ? lfsrB[1:0] : lfsrA[1:0];
         if (selB) begin
            qB.push_back(e);
         end else begin
            qA.push_back(e);
            lastLaneA = e.lane;
         end
      end
      frameTick = 1'b1;
      {billDone, shellDone, dcoinDone} = doneBits;
      @(negedge clk);
      frameTick = 1'b0;
      {billDone, shellDone, dcoinDone} = 3'b000;
      @(negedge clk);
      if (expSpawn) begin
         check("spawn_on_time", selB ? qB.size() : qA.size(), 0);
      end
   endtask

   task automatic idleTicks(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, 3'b000, 2'd0, 3'b000);
      end
   endtask

   task automatic doDone(input logic [2:0] doneBits);
      @(negedge clk);
      {billDone, shellDone, dcoinDone} = doneBits;
      @(negedge clk);
      {billDone, shellDone, dcoinDone} = 3'b000;
   endtask

   task automatic doStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rstA = 1'b0; rstB = 1'b0; frameTick = 1'b0; start = 1'b0; gameOver = 1'b0;
      billDone = 1'b0; shellDone = 1'b0; dcoinDone = 1'b0; lastLaneA = 2'd0;

      // Reset and idle behaviour
      repeat (2) @(negedge clk);
      check("A_reset_outputs", {billA, shellA, dcoinA, pulseA, idA, laneA, stateA}, 0);
      rstA = 1'b1;
      @(negedge clk);
      check("A_idle_state", stateA, 0);
      idleTicks(3);
      doStart();
      check("A_run_after_start", stateA, 1);

      // Bill spawns on the 5th tick; shell loses round robin and is then capped
      idleTicks(4);
      tick(1'b1, 3'b000, 2'd0, 3'b100);
      idleTicks(3);
      doDone(3'b100);
      check("A_bill_cleared", {billA, shellA, dcoinA}, 3'b000);
      tick(1'b1, 3'b000, 2'd1, 3'b010);

      // Dragon coin beats a simultaneously eligible bill; bill follows a tick later
      idleTicks(11);
      doDone(3'b010);
      tick(1'b1, 3'b000, 2'd2, 3'b001);
      tick(1'b1, 3'b000, 2'd0, 3'b101);

      // Done on a tick reloads instead of making the coin eligible
      tick(1'b0, 3'b001, 2'd0, 3'b000);
      check("A_dcoin_done_on_tick", {billA, shellA, dcoinA}, 3'b100);

      // Freeze, ignore dones and ticks, then restart
      @(negedge clk);
      gameOver = 1'b1;
      @(negedge clk);
      check("A_frozen_state", stateA, 2);
      doDone(3'b111);
      idleTicks(50);
      check("A_frozen_flags", {billA, shellA, dcoinA}, 3'b100);
      check("A_frozen_still", stateA, 2);
      check("A_frozen_id", idA, 0);
      check("A_frozen_lane", laneA, lastLaneA);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      gameOver = 1'b0;
      check("A_restart_state", stateA, 1);
      check("A_restart_flags", {billA, shellA, dcoinA}, 3'b000);
      idleTicks(4);
      tick(1'b1, 3'b000, 2'd0, 3'b100);

      // Reset in the middle of a run
      @(negedge clk);
      rstA = 1'b0;
      @(negedge clk);
      check("A_midrun_reset", {billA, shellA, dcoinA, pulseA, idA, laneA, stateA}, 0);

      // Two-hazard instance: round robin alternates the first grant
      selB = 1'b1;
      rstB = 1'b1;
      @(negedge clk);
      doStart();
      check("B_run_after_start", stateB, 1);
      idleTicks(4);
      tick(1'b1, 3'b000, 2'd0, 3'b100);
      tick(1'b1, 3'b000, 2'd1, 3'b110);
      doDone(3'b110);
      check("B_both_cleared", {billB, shellB, dcoinB}, 3'b000);
      idleTicks(4);
      tick(1'b1, 3'b000, 2'd1, 3'b010);
      tick(1'b1, 3'b000, 2'd0, 3'b110);

      repeat (3) @(negedge clk);
      check("A_queue_drained", qA.size(), 0);
      check("B_queue_drained", qB.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
